// File: rtl/sha_msg_schedule.sv
// SHA-256 message schedule: W0..W15 pass through, W16..W63 expand from a 16-word window; 1-cycle registered output.
// Backpressure: while out_valid && !out_ready the slot holds, in_ready drops and expansion stalls.
module sha_msg_schedule #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              done,
  input  logic [DATA_W-1:0] in0,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  state_t                  state, state_nx;
  logic [5:0]              cnt, cnt_nx;
  logic [15:0][DATA_W-1:0] w;
  logic                    slot_free, accept, issue, push;
  logic [DATA_W-1:0]       new_w, push_dat;

  function automatic logic [DATA_W-1:0] sigma0(input logic [DATA_W-1:0] x);
    return {x[6:0], x[DATA_W-1:7]} ^ {x[17:0], x[DATA_W-1:18]} ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] sigma1(input logic [DATA_W-1:0] x);
    return {x[16:0], x[DATA_W-1:17]} ^ {x[18:0], x[DATA_W-1:19]} ^ (x >> 10);
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == LOAD) && slot_free;
  assign done      = (state == IDLE) && !out_valid;
  assign accept    = in_valid && in_ready;
  assign issue     = (state == EXPAND) && slot_free;
  assign push      = accept || issue;

  // w[14]=W(t-2), w[9]=W(t-7), w[1]=W(t-15), w[0]=W(t-16)
  assign new_w    = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0];
  assign push_dat = issue ? new_w : in0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (run) begin
          cnt_nx   = '0;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_nx = cnt + 6'd1;
          if (cnt == 6'd15) state_nx = EXPAND;
        end
      end
      EXPAND: begin
        if (slot_free) begin
          cnt_nx = cnt + 6'd1;
          if (cnt == 6'd63) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w         <= '0;
      out0      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        w         <= {push_dat, w[15:1]};
        out0      <= push_dat;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
